// File: rtl/npc_ifu.sv
// NPC instruction fetch unit: owns the PC, issues one word fetch at a time over a
// valid/ready request channel, and buffers one instruction for the decoder with
// the RISC-V register/opcode fields pre-sliced. Redirects discard stale fetches.
module npc_ifu #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    // Instruction memory request channel
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    // Instruction memory response channel (no back-pressure)
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    input  logic            imem_rsp_err_i,
    // Decoder side
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic [6:0]      op_o,
    output logic [2:0]      func3_o,
    output logic [6:0]      func7_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic            fetch_err_o,
    // Branch/jump redirect
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StHalt = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            inst_valid_q, inst_valid_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            fetch_err_q, fetch_err_d;

    logic            pop;
    logic            req_valid;
    logic            req_hs;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_plus4;

    // Redirect targets are forced to word alignment, so the low bits are dropped.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc_i[1:0];

    assign pop             = inst_valid_q & inst_ready_i;
    // Only fetch when the buffer will be empty by the time the response lands.
    assign req_valid       = (state_q == StReq) & (~inst_valid_q | inst_ready_i);
    assign req_hs          = req_valid & imem_req_ready_i;
    assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign pc_plus4        = pc_q + {{(XLEN-3){1'b0}}, 3'd4};

    // Next-state logic: FSM, PC, kill flag and the one-entry buffer.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        inst_valid_d = inst_valid_q & ~pop;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fetch_err_d  = fetch_err_q;

        case (state_q)
            StIdle: begin
                state_d = StReq;
                if (redirect_valid_i) begin
                    pc_d = redirect_target;
                end
            end
            StReq: begin
                if (redirect_valid_i) begin
                    pc_d         = redirect_target;
                    inst_valid_d = 1'b0;
                    // An accepted request at the old PC must be discarded when it returns.
                    if (req_hs) begin
                        state_d = StWait;
                        kill_d  = 1'b1;
                    end
                end else if (req_hs) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (redirect_valid_i) begin
                    pc_d         = redirect_target;
                    inst_valid_d = 1'b0;
                    if (imem_rsp_valid_i) begin
                        state_d = StReq;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rsp_valid_i) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end else if (!imem_rsp_err_i) begin
                        inst_valid_d = 1'b1;
                        inst_d       = imem_rsp_data_i;
                        inst_pc_d    = pc_q;
                        fetch_err_d  = 1'b0;
                        pc_d         = pc_plus4;
                        state_d      = StReq;
                    end else begin
                        // Access fault: hand the faulting PC to the decoder and park.
                        inst_valid_d = 1'b1;
                        inst_d       = 32'h0;
                        inst_pc_d    = pc_q;
                        fetch_err_d  = 1'b1;
                        state_d      = StHalt;
                    end
                end
            end
            StHalt: begin
                if (redirect_valid_i) begin
                    pc_d         = redirect_target;
                    inst_valid_d = 1'b0;
                    state_d      = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'h0;
            inst_pc_q    <= '0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = {pc_q[XLEN-1:2], 2'b00};

    assign inst_valid_o = inst_valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign fetch_err_o  = fetch_err_q;

    // Field slices hold their last value after a pop since inst_q is not cleared.
    assign op_o    = inst_q[6:0];
    assign rd_o    = inst_q[11:7];
    assign func3_o = inst_q[14:12];
    assign rs1_o   = inst_q[19:15];
    assign rs2_o   = inst_q[24:20];
    assign func7_o = inst_q[31:25];

endmodule

// File: doc/npc_ifu.md
Name: npc_ifu

Overview:
- Instruction fetch unit for the NPC core. Sits directly upstream of the instruction decoder.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel with a separate response channel.
- Buffers one fetched instruction and presents it, pre-sliced into op/func3/func7/register fields, to the decoder with a valid/ready handshake.
- Accepts PC redirects from the branch/jump unit and discards any in-flight stale fetch.

Parameters:
RESET_PC  32'h8000_0000  PC loaded on reset
XLEN  32  address/data width

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous reset, active-low
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  fetch address (word aligned)
imem_rsp_valid  input  1  response valid, one cycle, cannot be back-pressured
imem_rsp_data  input  32  fetched instruction
imem_rsp_err  input  1  access fault, qualified by imem_rsp_valid
inst_valid  output  1  buffered instruction valid
inst_ready  input  1  decoder consumes instruction
inst  output  32  buffered instruction
inst_pc  output  XLEN  PC of buffered instruction
op  output  7  inst[6:0]
func3  output  3  inst[14:12]
func7  output  7  inst[31:25]
rs1  output  5  inst[19:15]
rs2  output  5  inst[24:20]
rd  output  5  inst[11:7]
fetch_err  output  1  buffered entry is an access fault
redirect_valid  input  1  branch/jump redirect, single-cycle pulse
redirect_pc  input  XLEN  redirect target

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE, kill=0.
  - Buffer empty; inst_valid=0, inst=0, inst_pc=0, fetch_err=0.
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - Reset asserted mid-transaction abandons it; any response arriving after reset release while in IDLE is ignored.
- Field outputs are combinational slices of the buffered inst. They equal 0 when the buffer is empty after reset, and hold the last value after a pop.
- imem_req_addr = {pc[XLEN-1:2],2'b00} at all times.
- States:
  - IDLE: exactly one cycle after reset release, then REQ.
  - REQ: imem_req_valid=1 only when the buffer is empty, or is popped this cycle (inst_valid&inst_ready). On req_valid&req_ready, go to WAIT.
  - WAIT: req_valid=0. On rsp_valid:
    - If kill=1: drop the response, clear kill, go to REQ.
    - If rsp_err=0: load buffer {inst=rsp_data, inst_pc=pc, fetch_err=0}, pc<=pc+4 (wraps modulo 2^XLEN), go to REQ.
    - If rsp_err=1: load buffer {inst=0, inst_pc=pc, fetch_err=1}, pc unchanged, go to HALT.
  - HALT: no requests. Leave only on redirect.
- Response-to-inst_valid latency: 1 cycle (registered). Best-case throughput: one instruction per 2 cycles with zero-wait memory.
- Buffer pop: inst_valid&inst_ready clears inst_valid next cycle. A load and a pop in the same cycle cannot occur, because a request is issued only when the buffer will be empty.
- Redirect (highest priority, any state except IDLE):
  - pc<=redirect_pc with bits [1:0] cleared.
  - Buffer flushed (inst_valid=0 next cycle), including a same-cycle pop. A same-cycle pop is still counted as consumed by the decoder.
  - REQ without handshake: next state REQ, new address next cycle. Withdrawing an unaccepted request is legal on this memory interface.
  - REQ with handshake in the same cycle: next state WAIT, kill=1.
  - WAIT, no rsp this cycle: stay WAIT, kill=1.
  - WAIT, rsp this cycle: drop the response, go to REQ.
  - HALT: go to REQ.
  - In IDLE, redirect updates pc only; the state still advances to REQ.
- imem_req_valid, inst_valid and fetch_err are driven from registers/state only; none combinationally depends on rsp inputs.

Test Plan:
- Reset, zero-wait memory returning 0x00500093 for addr 0x80000000 and 0x00100113 for 0x80000004, inst_ready=1 → first req addr 0x80000000 two cycles after rst_n rises; inst=0x00500093, op=0x13, rd=1, inst_pc=0x80000000; next inst_pc=0x80000004.
- inst_ready=0 for 5 cycles after first inst_valid → inst/inst_pc stable, no new imem_req_valid; raise ready → next request issued the same cycle.
- Redirect to 0x80000102 while in WAIT (rsp delayed 3 cycles) → stale response dropped, next req addr 0x80000100, inst_pc=0x80000100.
- Redirect in same cycle as request handshake at 0x80000008 → response for 0x80000008 never reaches inst; next req addr is the redirect target.
- rsp_err=1 at 0x80000010 → inst_valid=1, fetch_err=1, inst=0, inst_pc=0x80000010, no further requests; redirect to 0x80000000 → fetching resumes, fetch_err=0.
- Assert rst_n=0 during WAIT, then release with a late rsp_valid pulse in IDLE → pulse ignored, first new request at 0x80000000, inst_valid stays 0 until its response.
